// File: rtl/delay_table_gen.sv
// delay_table_gen: streams one quantised delay index per microphone for a
// single focus pixel. Each channel's squared distance to the pixel is compared
// against a monotone threshold table inside a 3-stage pipeline. The whole
// pipeline freezes while the output is stalled.
// Optional feature: define DELAY_GEN_THR_WR_EN to add a runtime threshold
// write port (thr_we/thr_addr/thr_data). Without it the thresholds are constants.
module delay_table_gen #(
    parameter int N_ROW      = 4,
    parameter int N_COL      = 4,
    parameter int PITCH      = 80,
    parameter int PX_W       = 7,
    parameter int PY_W       = 6,
    parameter int N_THR      = 32,
    parameter int DELTA_BASE = 147,
    parameter int R2_W       = 19,
    localparam int NCH  = N_ROW * N_COL,
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
`ifdef DELAY_GEN_THR_WR_EN
    input  logic                       thr_we,
    input  logic [$clog2(N_THR)-1:0]   thr_addr,
    input  logic [R2_W-1:0]            thr_data,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [PX_W-1:0]     p_x,
    input  logic signed [PY_W-1:0]     p_y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CH_W-1:0]            out_ch,
    output logic [7:0]                 out_delta,
    output logic                       out_last
);
    localparam int STAGES = 3;
    localparam int MAXN   = (N_ROW > N_COL) ? N_ROW : N_COL;
    localparam int MAXOFF = (MAXN - 1) * PITCH / 2;
    localparam int OFF_W  = $clog2(MAXOFF + 1) + 1;
    localparam int IN_W   = (PX_W > PY_W) ? PX_W : PY_W;
    // one guard bit over the widest operand keeps p + offset wrap-free
    localparam int CW     = ((IN_W > OFF_W) ? IN_W : OFF_W) + 1;
    localparam int SQ_W   = 2 * CW;
    localparam int SUM_W  = SQ_W + 1;
    localparam int CNT_W  = $clog2(N_THR + 1);
    localparam int RW_W   = (N_ROW > 1) ? $clog2(N_ROW) : 1;
    localparam int CL_W   = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam logic [R2_W-1:0] R2_MAX = '1;

    // default bin radii; squared to form the reset threshold table
    localparam int R_TAB [32] = '{ 62, 112, 146, 173, 197, 219, 239, 257,
                                  274, 290, 306, 321, 335, 349, 362, 375,
                                  388, 400, 412, 424, 436, 447, 458, 469,
                                  479, 490, 500, 510, 520, 530, 540, 550};

    function automatic logic [R2_W-1:0] thr_default(input int k);
        if (k < 32) return R2_W'(R_TAB[5'(k)] * R_TAB[5'(k)]);
        return '1;
    endfunction

    // centred element offset: (n-1-2*i)*PITCH/2, exact because PITCH is even
    function automatic logic signed [OFF_W-1:0] ax_off(input int n, input int i);
        return OFF_W'((n - 1 - 2 * i) * PITCH / 2);
    endfunction

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                   state;
    logic signed [PX_W-1:0]   px_q;
    logic signed [PY_W-1:0]   py_q;
    logic [CH_W-1:0]          ch_cnt;
    logic [RW_W-1:0]          row_cnt;
    logic [CL_W-1:0]          col_cnt;
    logic                     issued_all;
    logic                     issue, advance;
    logic [STAGES:1]          vld_pipe;
    logic signed [CW-1:0]     xs, ys;
    logic signed [SQ_W-1:0]   xe, ye;
    logic [SQ_W-1:0]          s1_xx, s1_yy;
    logic [CH_W-1:0]          s1_ch, s2_ch;
    logic [SUM_W-1:0]         sum;
    logic [R2_W-1:0]          s2_r2;
    logic [CNT_W-1:0]         gt_cnt;
    logic [R2_W-1:0]          thr [N_THR];

    assign out_valid = vld_pipe[STAGES];
    assign advance   = !(out_valid && !out_ready);
    assign issue     = (state == BUSY) && !issued_all;

`ifdef DELAY_GEN_THR_WR_EN
    // threshold table: writable only while idle so it is constant within a pixel
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < N_THR; k++) thr[k] <= thr_default(k);
        end else if (thr_we && state == IDLE && int'(thr_addr) < N_THR) begin
            thr[thr_addr] <= thr_data;
        end
    end
`else
    for (genvar k = 0; k < N_THR; k++) begin : g_thr
        assign thr[k] = thr_default(k);
    end
`endif

    // request FSM: latch the pixel, walk channels in row-major order, and
    // release once the final channel has landed in the output register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            px_q       <= '0;
            py_q       <= '0;
            ch_cnt     <= '0;
            row_cnt    <= '0;
            col_cnt    <= '0;
            issued_all <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    px_q       <= p_x;
                    py_q       <= p_y;
                    ch_cnt     <= '0;
                    row_cnt    <= '0;
                    col_cnt    <= '0;
                    issued_all <= 1'b0;
                    state      <= BUSY;
                    in_ready   <= 1'b0;
                end
                BUSY: begin
                    if (advance && !issued_all) begin
                        if (ch_cnt == CH_W'(NCH - 1)) begin
                            issued_all <= 1'b1;
                        end else begin
                            ch_cnt <= ch_cnt + 1'b1;
                            if (col_cnt == CL_W'(N_COL - 1)) begin
                                col_cnt <= '0;
                                row_cnt <= row_cnt + 1'b1;
                            end else begin
                                col_cnt <= col_cnt + 1'b1;
                            end
                        end
                    end
                    if (advance && vld_pipe[2] && s2_ch == CH_W'(NCH - 1)) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // S1 operands: sign-extended coordinate plus element offset, then squared
    always_comb begin
        xs = CW'(px_q) + CW'(ax_off(N_COL, int'(col_cnt)));
        ys = CW'(py_q) + CW'(ax_off(N_ROW, int'(row_cnt)));
        xe = SQ_W'(xs);
        ye = SQ_W'(ys);
        sum = SUM_W'(s1_xx) + SUM_W'(s1_yy);
    end

    // S3 bin count: number of thresholds strictly below r2
    always_comb begin
        gt_cnt = '0;
        for (int k = 0; k < N_THR; k++)
            if (s2_r2 > thr[k]) gt_cnt = gt_cnt + 1'b1;
    end

    // 3-stage datapath; every stage holds while the output beat is stalled
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_pipe  <= '0;
            s1_xx     <= '0;
            s1_yy     <= '0;
            s1_ch     <= '0;
            s2_r2     <= '0;
            s2_ch     <= '0;
            out_ch    <= '0;
            out_delta <= '0;
            out_last  <= 1'b0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], issue};
            s1_xx    <= xe * xe;
            s1_yy    <= ye * ye;
            s1_ch    <= ch_cnt;
            s2_r2    <= (sum > SUM_W'(R2_MAX)) ? R2_MAX : R2_W'(sum);
            s2_ch    <= s1_ch;
            if (vld_pipe[2]) begin
                out_ch    <= s2_ch;
                out_delta <= 8'(DELTA_BASE + int'(gt_cnt));
                out_last  <= (s2_ch == CH_W'(NCH - 1));
            end
        end
    end
endmodule

// File: tb/tb_delay_table_gen.sv
// Scoreboard bench for delay_table_gen: stimulus pushes the expected 16-beat
// stream per accepted pixel; a negedge monitor compares each presented beat.
module tb_delay_table_gen;
    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b1;
    logic              in_ready, out_valid, out_last;
    logic signed [6:0] p_x = '0;
    logic signed [5:0] p_y = '0;
    logic [3:0]        out_ch;
    logic [7:0]        out_delta;
`ifdef DELAY_GEN_THR_WR_EN
    logic              thr_we = 1'b0;
    logic [4:0]        thr_addr = '0;
    logic [18:0]       thr_data = '0;
`endif

    typedef struct {
        int ch;
        int delta;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   thr_m[32];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   rand_rdy = 1'b0;

    localparam int R_LIST[32] = '{ 62, 112, 146, 173, 197, 219, 239, 257,
                                  274, 290, 306, 321, 335, 349, 362, 375,
                                  388, 400, 412, 424, 436, 447, 458, 469,
                                  479, 490, 500, 510, 520, 530, 540, 550};

    delay_table_gen dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
`ifdef DELAY_GEN_THR_WR_EN
        .thr_we    (thr_we),
        .thr_addr  (thr_addr),
        .thr_data  (thr_data),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p_x       (p_x),
        .p_y       (p_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_delta (out_delta),
        .out_last  (out_last)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc++;

    // consumer: always ready, or a coin flip per cycle during stall tests
    always @(posedge i_clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
    end

    // monitor: every presented beat must match the head of the queue,
    // including each cycle it is held under backpressure
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got ch=%0d delta=%0d, expected no beat", out_ch, out_delta);
            end else begin
                e = exp_q[0];
                if (int'(out_ch) != e.ch || int'(out_delta) != e.delta || out_last != e.last) begin
                    errors++;
                    $display("FAIL beat: got ch=%0d delta=%0d last=%0d, expected ch=%0d delta=%0d last=%0d",
                             out_ch, out_delta, out_last, e.ch, e.delta, e.last);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // reference: geometry from the array layout, bin = thresholds strictly below r2
    function automatic int model_delta(input int px, input int py, input int ch);
        int row, col, x, y, r2, n;
        row = ch / 4;
        col = ch % 4;
        x = px + (3 - 2 * col) * 40;
        y = py + (3 - 2 * row) * 40;
        r2 = x * x + y * y;
        if (r2 > 524287) r2 = 524287;
        n = 0;
        for (int k = 0; k < 32; k++) if (r2 > thr_m[k]) n++;
        return 147 + n;
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 32; k++) thr_m[k] = R_LIST[k] * R_LIST[k];
    endtask

    task automatic send_pixel(input int px, input int py);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 300) begin
            step();
            n++;
        end
        if (!in_ready) begin
            fail("in_ready_timeout", 0, 1);
            return;
        end
        p_x = 7'(px);
        p_y = 6'(py);
        in_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            e.ch = c;
            e.delta = model_delta(px, py, c);
            e.last = (c == 15);
            exp_q.push_back(e);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) fail("drain_timeout_beats_left", exp_q.size(), 0);
    endtask

`ifdef DELAY_GEN_THR_WR_EN
    task automatic wr_thr(input int a, input int d);
        thr_we = 1'b1;
        thr_addr = 5'(a);
        thr_data = 19'(d);
        step();
        thr_we = 1'b0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n;
        reset_model();
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_ch", int'(out_ch), 0);
        check("rst_out_delta", int'(out_delta), 0);
        check("rst_out_last", int'(out_last), 0);
        i_rst = 1'b0;
        step();

        // latency of first beat and release of in_ready with no stalls
        send_pixel(0, 0);
        c0 = cyc;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("first_beat_latency", cyc - c0, 3);
        n = 0;
        while (!in_ready && n < 60) begin
            step();
            n++;
        end
        check("in_ready_return_cycle", cyc - c0, 18);
        drain();

        // directed geometry cases: bin edges, exact equality, negative coordinates
        send_pixel(-2, 0);
        send_pixel(22, 0);
        send_pixel(-40, 22);
        send_pixel(-40, -29);
        send_pixel(-64, -32);
        send_pixel(63, 31);
        drain();

        // random backpressure
        rand_rdy = 1'b1;
        send_pixel(0, 0);
        send_pixel(13, -7);
        drain();
        rand_rdy = 1'b0;

        // request during BUSY must be ignored
        send_pixel(5, 9);
        step();
        step();
        check("busy_in_ready", int'(in_ready), 0);
        p_x = -7'sd60;
        p_y = 6'sd20;
        in_valid = 1'b1;
        repeat (5) step();
        in_valid = 1'b0;
        drain();

        // reset mid-stream at beat 7
        send_pixel(17, -11);
        n = 0;
        while (!(out_valid && out_ch == 4'd7) && n < 100) begin
            step();
            n++;
        end
        if (!(out_valid && out_ch == 4'd7)) fail("beat7_timeout", int'(out_ch), 7);
        i_rst = 1'b1;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 1);
        exp_q.delete();
        reset_model();
        step();
        i_rst = 1'b0;
        send_pixel(-33, 14);
        drain();

        // randomized pixels, back-to-back, with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 12; i++)
            send_pixel(int'($urandom_range(127, 0)) - 64, int'($urandom_range(63, 0)) - 32);
        drain();
        rand_rdy = 1'b0;

`ifdef DELAY_GEN_THR_WR_EN
        // idle write takes effect
        wr_thr(0, 0);
        thr_m[0] = 0;
        send_pixel(0, 0);
        drain();
        // equality stays in the lower bin, one below moves up
        wr_thr(1, 5444);
        thr_m[1] = 5444;
        send_pixel(22, 0);
        drain();
        wr_thr(1, 5443);
        thr_m[1] = 5443;
        send_pixel(22, 0);
        drain();
        wr_thr(1, 12544);
        thr_m[1] = 12544;
        // write during BUSY is ignored
        wr_thr(0, 3844);
        thr_m[0] = 3844;
        send_pixel(0, 0);
        step();
        step();
        wr_thr(0, 0);
        drain();
        send_pixel(-2, 0);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
